// File: rtl/demux_4b_1to5_if.sv
// Bus bundle for the 1-to-5 steering demux: the data/select inputs going in,
// and the five steered outputs plus invalid-select diagnostics coming back.
interface demux_4b_1to5_if #(
  parameter int WIDTH     = 4,
  parameter int ERR_CNT_W = 8
);
  logic [WIDTH-1:0]     in_;
  logic [2:0]           sel;
  logic [WIDTH-1:0]     out0;
  logic [WIDTH-1:0]     out1;
  logic [WIDTH-1:0]     out2;
  logic [WIDTH-1:0]     out3;
  logic [WIDTH-1:0]     out4;
  logic                 sel_err;
  logic [ERR_CNT_W-1:0] err_cnt;

  // Source side: drives data and select, observes the steered outputs.
  modport master (
    output in_, sel,
    input  out0, out1, out2, out3, out4, sel_err, err_cnt
  );

  // Demux side: consumes data and select, drives the steered outputs.
  modport slave (
    input  in_, sel,
    output out0, out1, out2, out3, out4, sel_err, err_cnt
  );
endinterface

// File: rtl/demux_4b_1to5.sv
// 1-to-5 demultiplexer. The selected output carries in_, all others are zero.
// Select codes 5..7 are invalid: every output is zero, sel_err is raised and a
// saturating counter records how many clock edges saw an invalid select.
// REG_OUT=1 adds one register stage on the outputs and sel_err; the counter
// always samples the combinational error so it is identical in both modes.
module demux_4b_1to5 #(
  parameter int WIDTH     = 4,
  parameter int REG_OUT   = 0,
  parameter int ERR_CNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  demux_4b_1to5_if.slave     bus
);

  localparam logic [ERR_CNT_W-1:0] CNT_ONE = ERR_CNT_W'(1);
  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0]     out_c [5];
  logic                 sel_err_c;
  logic [ERR_CNT_W-1:0] err_cnt_q;

  // Steering decode: exactly one output gets in_, invalid codes zero them all.
  always_comb begin
    for (int k = 0; k < 5; k++) out_c[k] = '0;
    sel_err_c = 1'b0;
    case (bus.sel)
      3'd0:    out_c[0] = bus.in_;
      3'd1:    out_c[1] = bus.in_;
      3'd2:    out_c[2] = bus.in_;
      3'd3:    out_c[3] = bus.in_;
      3'd4:    out_c[4] = bus.in_;
      default: sel_err_c = 1'b1;
    endcase
  end

  // Invalid-select counter; sticks at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_cnt_q <= '0;
    end else if (sel_err_c && (err_cnt_q != CNT_MAX)) begin
      err_cnt_q <= err_cnt_q + CNT_ONE;
    end
  end

  assign bus.err_cnt = err_cnt_q;

  if (REG_OUT != 0) begin : g_reg
    logic [WIDTH-1:0] out_r [5];
    logic             sel_err_r;

    // Output stage: one cycle of latency, cleared immediately by reset.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        out_r     <= '{default: '0};
        sel_err_r <= 1'b0;
      end else begin
        out_r     <= out_c;
        sel_err_r <= sel_err_c;
      end
    end

    assign bus.out0    = out_r[0];
    assign bus.out1    = out_r[1];
    assign bus.out2    = out_r[2];
    assign bus.out3    = out_r[3];
    assign bus.out4    = out_r[4];
    assign bus.sel_err = sel_err_r;
  end else begin : g_comb
    assign bus.out0    = out_c[0];
    assign bus.out1    = out_c[1];
    assign bus.out2    = out_c[2];
    assign bus.out3    = out_c[3];
    assign bus.out4    = out_c[4];
    assign bus.sel_err = sel_err_c;
  end

endmodule

// File: tb/tb_demux_4b_1to5.sv
// Bench for demux_4b_1to5: one combinational and one registered instance share
// clock, reset and stimulus; a behavioural model predicts outputs and counter.
module tb_demux_4b_1to5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  int         exp_cnt = 0;
  logic [3:0] exp_reg [5] = '{default: 4'd0};
  logic       exp_reg_err = 1'b0;

  demux_4b_1to5_if #(.WIDTH(4), .ERR_CNT_W(8)) bus0 ();
  demux_4b_1to5_if #(.WIDTH(4), .ERR_CNT_W(8)) bus1 ();

  demux_4b_1to5 #(.WIDTH(4), .REG_OUT(0), .ERR_CNT_W(8)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0));
  demux_4b_1to5 #(.WIDTH(4), .REG_OUT(1), .ERR_CNT_W(8)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1));

  always #5 clk = ~clk;

  logic [3:0] c_out [5];
  logic [3:0] r_out [5];
  always_comb begin
    c_out[0] = bus0.out0; c_out[1] = bus0.out1; c_out[2] = bus0.out2;
    c_out[3] = bus0.out3; c_out[4] = bus0.out4;
    r_out[0] = bus1.out0; r_out[1] = bus1.out1; r_out[2] = bus1.out2;
    r_out[3] = bus1.out3; r_out[4] = bus1.out4;
  end

  function automatic logic [3:0] exp_out(input logic [3:0] d, input logic [2:0] s, input int k);
    return (int'(s) == k) ? d : 4'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] d, input logic [2:0] s);
    bus0.in_ = d; bus0.sel = s;
    bus1.in_ = d; bus1.sel = s;
  endtask

  task automatic chk_reg(input string tag);
    for (int k = 0; k < 5; k++)
      chk($sformatf("%s_reg_out%0d", tag, k), 32'(r_out[k]), 32'(exp_reg[k]));
    chk({tag, "_reg_sel_err"}, 32'(bus1.sel_err), 32'(exp_reg_err));
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_cnt_comb"}, 32'(bus0.err_cnt), 32'(exp_cnt));
    chk({tag, "_cnt_reg"},  32'(bus1.err_cnt), 32'(exp_cnt));
  endtask

  // One cycle: drive between edges, check comb + pre-edge registered state,
  // advance the model at the edge, then check counter and registered outputs.
  task automatic step(input logic [3:0] d, input logic [2:0] s, input string tag);
    @(negedge clk);
    drive(d, s);
    #1;
    for (int k = 0; k < 5; k++)
      chk($sformatf("%s_out%0d", tag, k), 32'(c_out[k]), 32'(exp_out(d, s, k)));
    chk({tag, "_sel_err"}, 32'(bus0.sel_err), 32'(s >= 3'd5));
    chk_reg({tag, "_pre"});
    @(posedge clk);
    if (reset) begin
      if (s >= 3'd5 && exp_cnt < 255) exp_cnt = exp_cnt + 1;
      for (int k = 0; k < 5; k++) exp_reg[k] = exp_out(d, s, k);
      exp_reg_err = (s >= 3'd5);
    end
    #1;
    chk_cnt(tag);
    chk_reg({tag, "_post"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] rd;
    logic [2:0] rs;
    drive(4'd0, 3'd0);
    #1;
    chk_cnt("reset");
    chk_reg("reset");

    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i <= 8; i++) step(4'(i), 3'd0, $sformatf("sweep%0d", i));

    for (int s = 1; s <= 4; s++)
      for (int d = 0; d <= 1; d++)
        step(4'(d), 3'(s), $sformatf("sel%0d_in%0d", s, d));

    for (int s = 5; s <= 7; s++)
      for (int d = 0; d <= 1; d++)
        step(4'(d), 3'(s), $sformatf("bad%0d_in%0d", s, d));

    for (int i = 0; i < 20; i++) begin
      rd = 4'($urandom_range(0, 15));
      rs = 3'($urandom_range(0, 7));
      step(rd, rs, $sformatf("rnd%0d", i));
    end

    for (int i = 0; i < 256 + 5; i++) step(4'hF, 3'd7, "sat");
    chk_cnt("sat_final");

    step(4'd0, 3'd0, "regmode_pre");
    step(4'hA, 3'd2, "regmode");
    chk("regmode_out2", 32'(bus1.out2), 32'h0A);

    @(negedge clk);
    reset = 1'b0;
    drive(4'd5, 3'd1);
    #1;
    exp_cnt = 0;
    exp_reg = '{default: 4'd0};
    exp_reg_err = 1'b0;
    chk_cnt("midreset");
    chk_reg("midreset");
    chk("midreset_comb_out1", 32'(bus0.out1), 32'd5);
    chk("midreset_comb_out2", 32'(bus0.out2), 32'd0);

    @(negedge clk);
    drive(4'd0, 3'd0);
    #1;
    reset = 1'b1;
    step(4'd3, 3'd6, "after_reset");
    step(4'd9, 3'd4, "after_reset2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_4b_1to5.md
Name: demux_4b_1to5

Overview:
- Combinational 1-to-5 demultiplexer with a 4-bit data path.
- Routes input data to the one output selected by a 3-bit select; every non-selected output is driven to zero.
- Adds an optional registered output stage and invalid-select diagnostics (error flag plus saturating counter), both clocked by the block clock.
- Used as a steering element for fanning one data bus out to five consumers.

Parameters:
- WIDTH, 4, data width of in_ and each out* port.
- REG_OUT, 0, 0 = outputs purely combinational; 1 = outputs registered (one-cycle latency).
- ERR_CNT_W, 8, width of the saturating invalid-select counter.

Ports:
- clk  input  1  block clock; used only by the error counter and by the optional output register.
- reset  input  1  asynchronous, active-low reset.
- in_  input  WIDTH  data to steer.
- sel  input  3  output select; valid range 0..4.
- out0  output  WIDTH  equals in_ when sel==0, else 0.
- out1  output  WIDTH  equals in_ when sel==1, else 0.
- out2  output  WIDTH  equals in_ when sel==2, else 0.
- out3  output  WIDTH  equals in_ when sel==3, else 0.
- out4  output  WIDTH  equals in_ when sel==4, else 0.
- sel_err  output  1  high when sel is 5, 6 or 7; follows the REG_OUT timing.
- err_cnt  output  ERR_CNT_W  count of clock edges sampled with sel_err asserted; saturates.

Behaviour:
- Mapping (sel value -> active output):
  - sel = k, k in 0..4: outk = in_, all other outputs = 0, sel_err = 0.
  - sel = 5, 6 or 7: all five outputs = 0, sel_err = 1.
  - At most one output is nonzero at any time.
- REG_OUT=0 (default):
  - out0..out4 and sel_err are purely combinational from in_ and sel.
  - Zero latency; outputs settle within the same cycle.
  - Not affected by clk or reset.
- REG_OUT=1:
  - out0..out4 and sel_err are captured on the rising clk edge from the combinational values.
  - One-cycle latency.
  - Reset value 0 for all registered outputs.
- err_cnt:
  - Increments by 1 on each rising clk edge where the combinational sel_err is 1.
  - Holds at all-ones once reached; no wrap-around.
  - Reset value 0.
  - Independent of REG_OUT.
- Reset:
  - reset low forces err_cnt to 0 (and the output registers to 0 when REG_OUT=1) immediately, without waiting for a clock edge.
  - Release is sampled on the next rising clk edge.
  - Reset asserted mid-operation clears all state immediately.
  - Combinational outputs (REG_OUT=0) keep following in_ and sel during reset.
- X or Z on sel is not defined behaviour; a bench must not drive it.
- No handshake; every cycle is independent.

Test Plan:
- Data sweep on select 0 (REG_OUT=0): sel=0, in_ = 0..8 -> out0 = in_; out1..out4 = 0; sel_err = 0.
- Per-output select: sel = 1..4 with in_ = 0 and 1 -> outk = in_ for k = sel; other outputs 0. Example: in_=1, sel=3 -> out3=1, others 0.
- Invalid select: sel = 5, 6, 7 with in_ = 0 and 1 -> all outputs 0, sel_err = 1; err_cnt increments once per rising edge spent in that state.
- Random: 20 pairs of random in_ (4-bit) and random sel (3-bit) -> outputs match the mapping rules; err_cnt equals the number of edges sampled with sel >= 5.
- Reset and saturation: hold sel=7 for 2^ERR_CNT_W + 5 edges -> err_cnt stops at all-ones. Then drop reset low between edges -> err_cnt = 0 immediately.
- Registered mode (REG_OUT=1): in_=0xA, sel=2 -> out2 = 0xA one edge later, 0 before that edge; asynchronous reset clears all outputs to 0.
